// File: rtl/link_pkg.sv
// Shared constants, sender state encoding and beat-slicing helper for the
// VC707 -> DE2115 word link.
package link_pkg;

    localparam int DATA_W = 32;
    localparam int CHAN_W = 6;
    localparam int BEATS  = (DATA_W + CHAN_W - 1) / CHAN_W;
    localparam int WORD_W = BEATS * CHAN_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } tx_state_t;

    // Returns beat n (LSB-first) of a zero-extended frame word.
    function automatic logic [CHAN_W-1:0] beat_slice(input logic [WORD_W-1:0] word,
                                                     input logic [2:0]        n);
        logic [WORD_W-1:0] shifted_s;
        shifted_s = word >> (32'(n) * CHAN_W);
        return shifted_s[CHAN_W-1:0];
    endfunction

endpackage

// File: rtl/link_rx.sv
// DE2115-side receiver: collects six channel beats and presents the word.
module link_rx
    import link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              com_req,
    input  logic              com_clk,
    input  logic [CHAN_W-1:0] com_channel,
    output logic [DATA_W-1:0] data_out,
    output logic              data_rdy_out
);

    logic [BEATS-2:0][CHAN_W-1:0] chunks_r;
    logic [2:0]                   rx_beat_r;
    logic [DATA_W-1:0]            data_out_r;
    logic                         data_rdy_out_r;
    logic                         unused_hi_s;

    // The top bits of the last beat are padding beyond the payload width.
    assign unused_hi_s = ^com_channel[CHAN_W-1:2];

    // Store beats while a frame is active; the last beat completes the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            chunks_r       <= '0;
            rx_beat_r      <= 3'd0;
            data_out_r     <= '0;
            data_rdy_out_r <= 1'b0;
        end else begin
            data_rdy_out_r <= 1'b0;
            if (!com_req) begin
                rx_beat_r <= 3'd0;
            end else if (com_clk) begin
                if (rx_beat_r == 3'(BEATS - 1)) begin
                    data_out_r     <= {com_channel[1:0], chunks_r};
                    data_rdy_out_r <= 1'b1;
                    rx_beat_r      <= 3'd0;
                end else begin
                    chunks_r[rx_beat_r] <= com_channel;
                    rx_beat_r           <= rx_beat_r + 3'd1;
                end
            end else begin
                rx_beat_r <= rx_beat_r;
            end
        end
    end

    assign data_out     = data_out_r;
    assign data_rdy_out = data_rdy_out_r;

endmodule

// File: rtl/vc707_de2115_link.sv
// VC707-side sender FSM serialising 32-bit words over a 6-bit strobed channel,
// looped into the DE2115-side receiver.
module vc707_de2115_link
    import link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_rdy,
    output logic              rdy_for_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_rdy_out,
    output logic [CHAN_W-1:0] com_channel,
    output logic              com_clk,
    output logic              com_req
);

    tx_state_t         state_r;
    logic [2:0]        beat_r;
    logic [WORD_W-1:0] word_r;
    logic              rdy_r;
    logic              com_req_r;
    logic              com_clk_r;
    logic [CHAN_W-1:0] com_chan_r;

    // Sender FSM: wire outputs follow the state one cycle later, while
    // rdy_for_data is updated together with the state transition so a new
    // word can be accepted the same edge com_req drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            beat_r     <= 3'd0;
            word_r     <= '0;
            rdy_r      <= 1'b1;
            com_req_r  <= 1'b0;
            com_clk_r  <= 1'b0;
            com_chan_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    com_req_r  <= 1'b0;
                    com_clk_r  <= 1'b0;
                    com_chan_r <= '0;
                    if (data_rdy && rdy_r) begin
                        word_r  <= {{(WORD_W - DATA_W){1'b0}}, data_in};
                        beat_r  <= 3'd0;
                        rdy_r   <= 1'b0;
                        state_r <= SETUP;
                    end else begin
                        rdy_r   <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    com_req_r  <= 1'b1;
                    com_clk_r  <= 1'b0;
                    com_chan_r <= beat_slice(word_r, beat_r);
                    state_r    <= STROBE;
                end
                STROBE: begin
                    com_clk_r <= 1'b1;
                    if (beat_r == 3'(BEATS - 1)) begin
                        rdy_r   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        beat_r  <= beat_r + 3'd1;
                        state_r <= SETUP;
                    end
                end
                default: begin
                    rdy_r      <= 1'b1;
                    com_req_r  <= 1'b0;
                    com_clk_r  <= 1'b0;
                    com_chan_r <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign rdy_for_data = rdy_r;
    assign com_req      = com_req_r;
    assign com_clk      = com_clk_r;
    assign com_channel  = com_chan_r;

    link_rx u_rx (
        .clk          (clk),
        .rst          (rst),
        .com_req      (com_req_r),
        .com_clk      (com_clk_r),
        .com_channel  (com_chan_r),
        .data_out     (data_out),
        .data_rdy_out (data_rdy_out)
    );

endmodule

// File: tb/tb_vc707_de2115_link.sv
// Self-checking bench for vc707_de2115_link against a cycle-count reference
// model of the link protocol.
module tb_vc707_de2115_link;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        data_rdy;
    logic        rdy_for_data;
    logic [31:0] data_out;
    logic        data_rdy_out;
    logic [5:0]  com_channel;
    logic        com_clk;
    logic        com_req;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          cyc = 0;
    int          ready_from = 0;
    int          acc_cyc = 0;
    bit          in_flight = 0;
    logic [31:0] acc_word = 32'd0;
    logic [31:0] last_out = 32'd0;
    int          due_q[$];
    logic [31:0] word_q[$];

    vc707_de2115_link dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_rdy     (data_rdy),
        .rdy_for_data (rdy_for_data),
        .data_out     (data_out),
        .data_rdy_out (data_rdy_out),
        .com_channel  (com_channel),
        .com_clk      (com_clk),
        .com_req      (com_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, update the model and compare every observable output.
    task automatic tick(output bit accepted);
        bit          acc;
        logic [31:0] din;
        int          d;
        bit          exp_req;
        bit          exp_clk;
        bit          exp_pulse;
        logic [35:0] w36;
        acc = (data_rdy === 1'b1) && (rst !== 1'b1) && (cyc >= ready_from);
        din = data_in;
        @(posedge clk);
        cyc++;
        if (rst === 1'b1) begin
            in_flight  = 1'b0;
            due_q.delete();
            word_q.delete();
            ready_from = cyc;
            last_out   = 32'd0;
            acc        = 1'b0;
        end else if (acc) begin
            in_flight  = 1'b1;
            acc_cyc    = cyc;
            acc_word   = din;
            ready_from = cyc + 12;
            due_q.push_back(cyc + 13);
            word_q.push_back(din);
        end
        accepted = acc;
        #1;
        d       = cyc - acc_cyc;
        exp_req = in_flight && (d >= 1) && (d <= 12);
        exp_clk = in_flight && (d >= 2) && (d <= 12) && (d % 2 == 0);
        check("rdy_for_data", {35'd0, rdy_for_data}, {35'd0, (cyc >= ready_from)});
        check("com_req", {35'd0, com_req}, {35'd0, exp_req});
        check("com_clk", {35'd0, com_clk}, {35'd0, exp_clk});
        if (exp_clk) begin
            w36 = {4'd0, acc_word};
            check("com_channel", {30'd0, com_channel}, (w36 >> (6 * (d / 2 - 1))) & 36'h3F);
        end
        exp_pulse = (due_q.size() > 0) && (due_q[0] == cyc);
        if (exp_pulse) begin
            last_out = word_q.pop_front();
            void'(due_q.pop_front());
        end
        check("data_rdy_out", {35'd0, data_rdy_out}, {35'd0, exp_pulse});
        check("data_out", {4'd0, data_out}, {4'd0, last_out});
    endtask

    // Hold data_rdy with a word until the model accepts it.
    task automatic send(input logic [31:0] w);
        bit got;
        int n;
        data_in  = w;
        data_rdy = 1'b1;
        got      = 1'b0;
        n        = 0;
        while (!got && n < 40) begin
            tick(got);
            n++;
        end
        data_rdy = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: word %0h not accepted, expected acceptance within 40 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        bit got;
        for (int i = 0; i < n; i++) tick(got);
    endtask

    initial begin
        bit got;
        rst      = 1'b1;
        data_in  = 32'd0;
        data_rdy = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(3);

        // Single small word, then all-ones word
        send(32'h0000_0002);
        idle(16);
        send(32'hFFFF_FFFF);
        idle(16);

        // Mid-frame data_rdy noise must be ignored
        send(32'h1234_5678);
        data_in  = 32'hAAAA_5555;
        data_rdy = 1'b1;
        while (cyc < ready_from - 1) tick(got);
        data_rdy = 1'b0;
        idle(16);

        // Streaming back-to-back words 2..101
        for (int k = 2; k <= 101; k++) send(32'(k));
        idle(16);

        // Reset during beat 3 discards the frame; next word still delivered
        send(32'hDEAD_BEEF);
        idle(7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(16);
        send(32'hCAFE_F00D);
        idle(16);

        // Random data_rdy / data_in traffic
        for (int i = 0; i < 400; i++) begin
            data_rdy = 1'($urandom_range(0, 1));
            data_in  = $urandom;
            tick(got);
        end
        data_rdy = 1'b0;
        idle(20);

        check("drain_pending", 36'(due_q.size()), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
